multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequences the iterative multiply/divide unit for the single-issue processor. Detects mul/div in execute, pulses the unit's start, and stalls the pipeline until a result arrives or a timeout fires. Then arbitrates one regfile write: rd gets the product/quotient, or $r30 (rstatus) gets code 4 (mul overflow) or 5 (div by zero / timeout). Complements the add/addi/sub rstatus logic, which covers codes 1-3.

Parameters:
TIMEOUT, 40, max cycles in BUSY before forcing an exception writeback
CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high
issue_valid  in  1  valid instruction in execute stage
opcode  in  5  instruction opcode
aluopcode  in  5  R-type ALU op field
rd  in  5  destination register
md_resultRDY  in  1  one-cycle pulse: unit result valid
md_exception  in  1  unit exception, qualified by md_resultRDY
md_result  in  32  unit result, qualified by md_resultRDY
ctrl_MULT  out  1  one-cycle start pulse for multiply
ctrl_DIV  out  1  one-cycle start pulse for divide
stall  out  1  freeze fetch/decode/execute
wb_valid  out  1  write request to shared regfile port
wb_reg  out  5  write address
wb_data  out  32  write data
wb_ready  in  1  regfile port granted this cycle
timeout_err  out  1  sticky flag; set on timeout, cleared by reset only

Behaviour:
- Decode: is_mul = opcode==00000 & aluopcode==00110; is_div = opcode==00000 & aluopcode==00111.
- States: IDLE, BUSY, WB.
- Reset (synchronous): state=IDLE, counter=0, ctrl_MULT=ctrl_DIV=0, stall=0, wb_valid=0, wb_reg=0, wb_data=0, timeout_err=0. Reset mid-BUSY or mid-WB aborts with no write.
- IDLE: on issue_valid & (is_mul|is_div):
  - assert ctrl_MULT or ctrl_DIV combinationally that cycle, for exactly one cycle;
  - latch rd and kind (mul/div); counter=0; go BUSY.
  - stall = (state!=IDLE) | start condition, so stall rises in the issue cycle.
- BUSY: counter +1 per cycle.
  - md_resultRDY: latch md_result and md_exception; go WB.
  - Else, counter==TIMEOUT-1: force exception, set timeout_err; go WB.
  - md_resultRDY in the timeout cycle: the result wins and timeout_err stays 0.
  - issue_valid is ignored (pipeline stalled).
- WB:
  - Exception: wb_reg=30, wb_data=4 (mul) or 5 (div), zero-extended to 32 bits.
  - Else: wb_reg=latched rd, wb_data=latched result.
  - No exception and rd==0: no write (wb_valid stays 0); return to IDLE next cycle.
  - Otherwise wb_valid=1, held with wb_reg/wb_data stable until wb_ready. In the wb_ready cycle the write commits; go IDLE.
  - stall stays high through the wb_ready cycle and drops the following cycle.
- Latency: issue to IDLE = unit latency + 1 (WB) + wb_ready wait cycles.
- md_resultRDY in IDLE or WB is ignored.
- A new mul/div in the first IDLE cycle after WB starts normally (back-to-back allowed).
- The rstatus write overrides rd: rd is not written on exception.

Decomposition:
- Shared package: opcode/ALU-op constants (R-type 00000, MUL 00110, DIV 00111); rstatus codes (ADD 1, ADDI 2, SUB 3, MUL 4, DIV 5); RSTATUS_REG=30; state encoding.
- One sub-module: md_cycle_counter (clear, enable, terminal-count compare against TIMEOUT-1).

Test Plan:
- Mul, rd=5, md_result=0x0000_0006 after 32 cycles, no exception, wb_ready=1 -> ctrl_MULT pulses once; stall high 34 cycles; wb_reg=5, wb_data=6.
- Div, md_exception=1 on md_resultRDY -> wb_reg=30, wb_data=5, rd untouched.
- Mul with no md_resultRDY, TIMEOUT=40 -> WB on cycle 40, wb_reg=30, wb_data=4, timeout_err=1 stays set.
- Mul completes, wb_ready low 3 cycles -> wb_valid/wb_reg/wb_data held stable 4 cycles; stall drops the cycle after the grant.
- Div with rd=0, no exception -> no wb_valid; IDLE one cycle after WB; reset pulsed mid-BUSY -> all outputs 0, no write.
- md_resultRDY in the timeout cycle -> result written, timeout_err=0; back-to-back mul in the next IDLE cycle -> new ctrl_MULT pulse.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared decode constants, rstatus codes and FSM encoding for the mul/div sequencer
package multdiv_pkg;
    localparam logic [4:0] OP_RTYPE    = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam logic [4:0] RSTATUS_REG = 5'd30;
    localparam logic [31:0] RSTATUS_ADD  = 32'd1;
    localparam logic [31:0] RSTATUS_ADDI = 32'd2;
    localparam logic [31:0] RSTATUS_SUB  = 32'd3;
    localparam logic [31:0] RSTATUS_MUL  = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;
    typedef enum logic [1:0] {IDLE, BUSY, WB} md_state_t;
    function automatic logic [31:0] md_status_code(input logic div);
        return div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction
endpackage

// File: rtl/multdiv_ctrl_counter.sv
// md_cycle_counter: BUSY cycle counter with terminal count at TIMEOUT-1
module md_cycle_counter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end
    assign tc = count == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: starts the iterative mul/div unit, stalls the pipe, and arbitrates the result or rstatus writeback
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  opcode,
    input  logic [4:0]  aluopcode,
    input  logic [4:0]  rd,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        timeout_err
);
    md_state_t   state, state_nx;
    logic        is_mul, is_div, start, tc;
    logic        div_q, exc_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q;

    assign is_mul = opcode == OP_RTYPE && aluopcode == ALU_MUL;
    assign is_div = opcode == OP_RTYPE && aluopcode == ALU_DIV;
    assign start  = state == IDLE && issue_valid && (is_mul || is_div);

    md_cycle_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (state == BUSY),
        .tc     (tc)
    );

    always_comb begin
        ctrl_MULT = start && is_mul;
        ctrl_DIV  = start && is_div;
        stall     = state != IDLE || start;
        wb_valid  = state == WB && (exc_q || rd_q != '0);
        wb_reg    = state == WB ? (exc_q ? RSTATUS_REG : rd_q) : '0;
        wb_data   = state == WB ? (exc_q ? md_status_code(div_q) : res_q) : '0;
        state_nx  = state == IDLE ? (start ? BUSY : IDLE) :
                    state == BUSY ? ((md_resultRDY || tc) ? WB : BUSY) :
                    (wb_valid && !wb_ready) ? WB : IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            div_q       <= 1'b0;
            exc_q       <= 1'b0;
            rd_q        <= '0;
            res_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                div_q <= is_div;
                rd_q  <= rd;
            end
            // a result arriving in the terminal-count cycle takes priority over the timeout
            if (state == BUSY && md_resultRDY) begin
                res_q <= md_result;
                exc_q <= md_exception;
            end else if (state == BUSY && tc) begin
                exc_q       <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: table-driven mul/div sequencing with a writeback scoreboard plus reset corner cases
module tb_multdiv_ctrl;
    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  opcode, aluopcode, rd;
    logic        md_resultRDY, md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_ready, timeout_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    multdiv_ctrl #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .opcode       (opcode),
        .aluopcode    (aluopcode),
        .rd           (rd),
        .md_resultRDY (md_resultRDY),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          div;
        logic [4:0]  r;
        int          lat;
        bit          exc;
        logic [31:0] res;
        int          wt;
        bit          b2b;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[10];
    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   exp_terr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample_wb();
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                chk("wb_reg", 32'(wb_reg), 32'(exp_q[0].r));
                chk("wb_data", wb_data, exp_q[0].d);
                if (wb_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic run_op(input vec_t v);
        bit   exc_eff, wr, done;
        int   wb_cyc, exp_end, n_mul, n_div, n_stall, n_wbv;
        wr_t  w;
        exc_eff = v.lat == 0 || v.exc;
        wr      = exc_eff || v.r != 5'd0;
        wb_cyc  = (v.lat > 0 && v.lat <= TO) ? v.lat + 1 : TO + 1;
        exp_end = wr ? wb_cyc + v.wt + 1 : wb_cyc + 1;
        if (v.lat == 0) exp_terr = 1;
        if (wr) begin
            w.r = exc_eff ? 5'd30 : v.r;
            w.d = exc_eff ? (v.div ? 32'd5 : 32'd4) : v.res;
            exp_q.push_back(w);
        end
        if (!v.b2b) begin
            @(posedge clock);
            #1;
        end
        issue_valid  = 1'b1;
        opcode       = 5'b00000;
        aluopcode    = v.div ? 5'b00111 : 5'b00110;
        rd           = v.r;
        md_resultRDY = 1'b0;
        wb_ready     = 1'b0;
        #2;
        n_mul   = int'(ctrl_MULT);
        n_div   = int'(ctrl_DIV);
        n_stall = int'(stall);
        n_wbv   = 0;
        done    = 0;
        for (int c = 1; c < 300; c++) begin
            @(posedge clock);
            #1;
            issue_valid  = c < exp_end;
            aluopcode    = v.div ? 5'b00110 : 5'b00111;
            rd           = 5'($urandom);
            md_resultRDY = c == v.lat || (c >= wb_cyc && c < exp_end);
            md_exception = c == v.lat ? v.exc : 1'b1;
            md_result    = c == v.lat ? v.res : ~v.res;
            wb_ready     = c >= wb_cyc + v.wt;
            @(negedge clock);
            sample_wb();
            n_mul += int'(ctrl_MULT);
            n_div += int'(ctrl_DIV);
            n_wbv += int'(wb_valid);
            if (!stall) begin
                done = 1;
                break;
            end
            n_stall++;
        end
        issue_valid  = 1'b0;
        md_resultRDY = 1'b0;
        wb_ready     = 1'b0;
        chk("stall_dropped", 32'(done), 32'd1);
        chk("mult_pulses", 32'(n_mul), v.div ? 32'd0 : 32'd1);
        chk("div_pulses", 32'(n_div), v.div ? 32'd1 : 32'd0);
        chk("stall_cycles", 32'(n_stall), 32'(exp_end));
        chk("wb_valid_cycles", 32'(n_wbv), wr ? 32'(v.wt + 1) : 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
        exp_q.delete();
    endtask

    initial begin
        int n_wbv, n_stall;
        vecs[0] = '{0, 5'd5,  32, 0, 32'h0000_0006, 0, 0};
        vecs[1] = '{1, 5'd9,  20, 1, 32'h0000_1234, 1, 0};
        vecs[2] = '{0, 5'd3,  8,  0, 32'hDEAD_BEEF, 3, 0};
        vecs[3] = '{1, 5'd0,  5,  0, 32'h0000_00AA, 0, 0};
        vecs[4] = '{0, 5'd12, TO, 0, 32'h0000_CAFE, 0, 0};
        vecs[5] = '{0, 5'd17, 3,  0, 32'h0000_0055, 0, 1};
        vecs[6] = '{1, 5'd0,  4,  1, 32'h0000_0011, 1, 0};
        vecs[7] = '{1, 5'd31, 1,  0, 32'hFFFF_FFFF, 2, 1};
        vecs[8] = '{0, 5'd6,  0,  0, 32'h0000_0000, 2, 0};
        vecs[9] = '{1, 5'd8,  0,  0, 32'h0000_0000, 0, 0};

        reset = 1'b1; issue_valid = 1'b0; opcode = '0; aluopcode = '0; rd = '0;
        md_resultRDY = 1'b0; md_exception = 1'b0; md_result = '0; wb_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        @(posedge clock);
        #1;
        issue_valid = 1'b1; aluopcode = 5'b00110; rd = 5'd7;
        #2;
        chk("mid_busy_start", 32'(ctrl_MULT), 32'd1);
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_terr = 0;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        chk("abort_wb_reg", 32'(wb_reg), 32'd0);
        chk("abort_wb_data", wb_data, 32'd0);
        chk("abort_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("abort_timeout_err", 32'(timeout_err), 32'd0);
        n_wbv = 0;
        n_stall = 0;
        for (int c = 0; c < TO + 5; c++) begin
            md_resultRDY = c == 5;
            md_exception = 1'b1;
            wb_ready = 1'b1;
            @(negedge clock);
            n_wbv += int'(wb_valid);
            n_stall += int'(stall);
            @(posedge clock);
            #1;
        end
        md_resultRDY = 1'b0;
        wb_ready = 1'b0;
        chk("abort_no_write", 32'(n_wbv), 32'd0);
        chk("abort_no_stall", 32'(n_stall), 32'd0);

        run_op('{0, 5'd4, 2, 0, 32'h0000_0077, 1, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
